// File: rtl/axil_reg_slave.sv
// rtl/axil_reg_slave.sv - AXI4-Lite slave register bank with flat register output
// Define AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_reg_slave #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH-1:0]          aw_addr_i,
  input  logic                           aw_valid_i,
  output logic                           aw_ready_o,
  input  logic [DATA_WIDTH-1:0]          w_data_i,
  input  logic [DATA_WIDTH/8-1:0]        w_strb_i,
  input  logic                           w_valid_i,
  output logic                           w_ready_o,
  output logic [1:0]                     b_resp_o,
  output logic                           b_valid_o,
  input  logic                           b_ready_i,
  input  logic [ADDR_WIDTH-1:0]          ar_addr_i,
  input  logic                           ar_valid_i,
  output logic                           ar_ready_o,
  output logic [DATA_WIDTH-1:0]          r_data_o,
  output logic [1:0]                     r_resp_o,
  output logic                           r_valid_o,
  input  logic                           r_ready_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  // Readies stay low through reset and rise on the first edge after release.
  logic                  active_q;
  logic                  aw_held_q;
  logic [IDX_W-1:0]      aw_idx_q;
  logic                  w_held_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  b_valid_q;
  logic [1:0]            b_resp_q;
  logic                  r_valid_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic [1:0]            r_resp_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  wr_commit;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [NUM_REGS-1:0]   wr_sel;
  logic                  wr_hit;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_hit;
  logic                  unused_addr_bits;

  assign aw_ready_o = active_q && !aw_held_q && !b_valid_q;
  assign w_ready_o  = active_q && !w_held_q && !b_valid_q;
  assign ar_ready_o = active_q && !r_valid_q;

  assign aw_hs = aw_valid_i && aw_ready_o;
  assign w_hs  = w_valid_i && w_ready_o;
  assign ar_hs = ar_valid_i && ar_ready_o;

  // A held half pairs with its partner's live handshake in the same cycle.
  assign wr_commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_idx    = aw_held_q ? aw_idx_q : aw_addr_i[ADDR_WIDTH-1:2];
  assign wr_data   = w_held_q ? w_data_q : w_data_i;
  assign wr_strb   = w_held_q ? w_strb_q : w_strb_i;
  assign rd_idx    = ar_addr_i[ADDR_WIDTH-1:2];

  assign unused_addr_bits = ^{aw_addr_i[1:0], ar_addr_i[1:0]};

  always_comb begin
    wr_sel  = '0;
    wr_hit  = 1'b0;
    rd_word = '0;
    rd_hit  = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (wr_idx == IDX_W'(k)) begin
        wr_sel[k] = 1'b1;
        wr_hit    = 1'b1;
      end
      if (rd_idx == IDX_W'(k)) begin
        rd_word = regs_q[k];
        rd_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q  <= 1'b0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
    end else begin
      active_q <= 1'b1;
      if (wr_commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_hit ? RESP_OKAY : RESP_OOR;
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          aw_idx_q  <= aw_addr_i[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_held_q <= 1'b1;
          w_data_q <= w_data_i;
          w_strb_q <= w_strb_i;
        end
        if (b_valid_q && b_ready_i) begin
          b_valid_q <= 1'b0;
        end
      end
    end
  end

  // Reads sample regs_q before a same-edge commit lands, giving the pre-write value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      r_valid_q <= 1'b1;
      r_data_q  <= rd_word;
      r_resp_q  <= rd_hit ? RESP_OKAY : RESP_OOR;
    end else if (r_valid_q && r_ready_i) begin
      r_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else if (wr_commit) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_sel[k] && wr_strb[b]) begin
            regs_q[k][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  assign b_valid_o = b_valid_q;
  assign b_resp_o  = b_resp_q;
  assign r_valid_o = r_valid_q;
  assign r_data_o  = r_data_q;
  assign r_resp_o  = r_resp_q;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// tb/tb_axil_reg_slave.sv - directed bench for axil_reg_slave
// A second instance with NUM_REGS=3 shares all inputs to observe out-of-range handling.
module tb_axil_reg_slave;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [3:0]   aw_addr = '0;
  logic         aw_valid = 1'b0;
  logic [31:0]  w_data = '0;
  logic [3:0]   w_strb = '0;
  logic         w_valid = 1'b0;
  logic         b_ready = 1'b1;
  logic [3:0]   ar_addr = '0;
  logic         ar_valid = 1'b0;
  logic         r_ready = 1'b1;

  logic         aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [1:0]   b_resp, r_resp;
  logic [31:0]  r_data;
  logic [127:0] regs;
  logic         aw_ready3, w_ready3, b_valid3, ar_ready3, r_valid3;
  logic [1:0]   b_resp3, r_resp3;
  logic [31:0]  r_data3;
  logic [95:0]  regs3;

  int checks = 0;
  int errors = 0;

`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  always #5 clk_i = ~clk_i;

  axil_reg_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(4)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
    .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
    .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
    .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
    .regs_o(regs)
  );

  axil_reg_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(3)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i),
    .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready3),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready3),
    .b_resp_o(b_resp3), .b_valid_o(b_valid3), .b_ready_i(b_ready),
    .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready3),
    .r_data_o(r_data3), .r_resp_o(r_resp3), .r_valid_o(r_valid3), .r_ready_i(r_ready),
    .regs_o(regs3)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [1:0] resp3);
    int cnt;
    @(negedge clk_i);
    aw_addr = a; aw_valid = 1'b1;
    w_data = d; w_strb = s; w_valid = 1'b1;
    cnt = 0;
    while (!(aw_ready && w_ready) && cnt < 20) begin
      @(negedge clk_i);
      cnt++;
    end
    chk("wr_accept_wait", cnt < 20, 1'b1);
    @(negedge clk_i);
    aw_valid = 1'b0; w_valid = 1'b0;
    cnt = 0;
    while (!b_valid && cnt < 20) begin
      @(negedge clk_i);
      cnt++;
    end
    chk("b_latency", cnt, 0);
    resp = b_resp;
    resp3 = b_resp3;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output logic [31:0] d3, output logic [1:0] resp3);
    int cnt;
    @(negedge clk_i);
    ar_addr = a; ar_valid = 1'b1;
    cnt = 0;
    while (!ar_ready && cnt < 20) begin
      @(negedge clk_i);
      cnt++;
    end
    chk("rd_accept_wait", cnt < 20, 1'b1);
    @(negedge clk_i);
    ar_valid = 1'b0;
    cnt = 0;
    while (!r_valid && cnt < 20) begin
      @(negedge clk_i);
      cnt++;
    end
    chk("r_latency", cnt, 0);
    d = r_data; resp = r_resp;
    d3 = r_data3; resp3 = r_resp3;
  endtask

  initial begin
    logic [1:0]  resp, resp3;
    logic [31:0] d, d3;

    // Reset held 5 cycles: every output low, readies included.
    repeat (5) @(negedge clk_i);
    chk("rst_aw_ready", aw_ready, 1'b0);
    chk("rst_w_ready", w_ready, 1'b0);
    chk("rst_ar_ready", ar_ready, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_regs", regs, 128'h0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_aw_ready", aw_ready, 1'b1);
    chk("post_rst_w_ready", w_ready, 1'b1);
    chk("post_rst_ar_ready", ar_ready, 1'b1);

    // Test 1: AW and W together.
    do_write(4'h0, 32'h10101010, 4'hF, resp, resp3);
    chk("t1_resp", resp, 2'b00);
    chk("t1_reg0", regs[31:0], 32'h10101010);
    chk("t1_aw_ready_during_b", aw_ready, 1'b0);

    // Test 2: back-to-back writes then read back.
    do_write(4'h4, 32'h20202020, 4'hF, resp, resp3);
    do_write(4'h8, 32'h30303030, 4'hF, resp, resp3);
    do_write(4'hC, 32'h40404040, 4'hF, resp, resp3);
    chk("t2_regs", regs, 128'h40404040_30303030_20202020_10101010);
    do_read(4'h0, d, resp, d3, resp3);
    chk("t2_rd0", d, 32'h10101010);
    do_read(4'h4, d, resp, d3, resp3);
    chk("t2_rd1", d, 32'h20202020);
    do_read(4'h8, d, resp, d3, resp3);
    chk("t2_rd2", d, 32'h30303030);
    do_read(4'hD, d, resp, d3, resp3);
    chk("t2_rd3_low_bits_ignored", d, 32'h40404040);
    chk("t2_rd3_resp", resp, 2'b00);

    // Test 3: W three cycles ahead of AW, partial strobes.
    @(negedge clk_i);
    w_data = 32'hAABBCCDD; w_strb = 4'b0101; w_valid = 1'b1;
    chk("t3_w_ready_before", w_ready, 1'b1);
    @(negedge clk_i);
    w_valid = 1'b0;
    chk("t3_w_held_ready0", w_ready, 1'b0);
    chk("t3_aw_ready_open", aw_ready, 1'b1);
    chk("t3_no_b_yet", b_valid, 1'b0);
    @(negedge clk_i);
    chk("t3_w_held_ready0_b", w_ready, 1'b0);
    @(negedge clk_i);
    chk("t3_w_held_ready0_c", w_ready, 1'b0);
    aw_addr = 4'h4; aw_valid = 1'b1;
    @(negedge clk_i);
    aw_valid = 1'b0;
    chk("t3_b_valid", b_valid, 1'b1);
    chk("t3_reg1", regs[63:32], 32'h20BB20DD);
    @(negedge clk_i);

    // Test 4: B stall of 4 cycles with new requests pending.
    b_ready = 1'b0;
    chk("t4_ready_start", {aw_ready, w_ready}, 2'b11);
    aw_addr = 4'h0; aw_valid = 1'b1;
    w_data = 32'h11111111; w_strb = 4'hF; w_valid = 1'b1;
    @(negedge clk_i);
    aw_addr = 4'h4; w_data = 32'h99999999;
    for (int i = 0; i < 4; i++) begin
      chk("t4_b_valid_held", b_valid, 1'b1);
      chk("t4_b_resp_held", b_resp, 2'b00);
      chk("t4_readies_low", {aw_ready, w_ready}, 2'b00);
      @(negedge clk_i);
    end
    aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b1;
    @(negedge clk_i);
    chk("t4_b_released", b_valid, 1'b0);
    chk("t4_readies_back", {aw_ready, w_ready}, 2'b11);
    chk("t4_single_commit", regs[63:0], 64'h20BB20DD_11111111);

    // Test 5: write and read of 0x8 on the same edge.
    aw_addr = 4'h8; aw_valid = 1'b1;
    w_data = 32'h00000055; w_strb = 4'hF; w_valid = 1'b1;
    ar_addr = 4'h8; ar_valid = 1'b1;
    @(negedge clk_i);
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    chk("t5_r_valid", r_valid, 1'b1);
    chk("t5_pre_write_data", r_data, 32'h30303030);
    chk("t5_b_valid", b_valid, 1'b1);
    chk("t5_reg2", regs[95:64], 32'h00000055);
    do_read(4'h8, d, resp, d3, resp3);
    chk("t5_later_read", d, 32'h00000055);

    // Test 6: 0xC is out of range for the 3-register instance.
    do_write(4'hC, 32'hDEADBEEF, 4'hF, resp, resp3);
    chk("t6_in_range_resp", resp, 2'b00);
    chk("t6_oor_wr_resp", resp3, EXP_OOR);
    chk("t6_reg3_written", regs[127:96], 32'hDEADBEEF);
    chk("t6_oor_regs_unchanged", regs3, 96'h00000055_20BB20DD_11111111);
    do_read(4'hC, d, resp, d3, resp3);
    chk("t6_oor_rd_data", d3, 32'h0);
    chk("t6_oor_rd_resp", resp3, EXP_OOR);
    chk("t6_in_range_rd", d, 32'hDEADBEEF);

    // Reset asserted while B is pending.
    @(negedge clk_i);
    b_ready = 1'b0;
    aw_addr = 4'h4; aw_valid = 1'b1;
    w_data = 32'h77777777; w_strb = 4'hF; w_valid = 1'b1;
    @(negedge clk_i);
    aw_valid = 1'b0; w_valid = 1'b0;
    chk("t6_b_pending", b_valid, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("t6_rst_drops_b", b_valid, 1'b0);
    chk("t6_rst_drops_b3", b_valid3, 1'b0);
    chk("t6_rst_regs", regs, 128'h0);
    chk("t6_rst_regs3", regs3, 96'h0);
    chk("t6_rst_readies", {aw_ready, w_ready, ar_ready}, 3'b000);
    @(negedge clk_i);
    rst_i = 1'b0; b_ready = 1'b1;
    @(negedge clk_i);
    chk("t6_post_rst_readies", {aw_ready, w_ready, ar_ready}, 3'b111);
    chk("t6_post_rst_b", b_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
